// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx
// Write-only I2C slave receiver. SCL/SDA are synchronized and edge-detected
// on clk; START/STOP framing drives a byte-level FSM that matches a 7-bit
// address, ACKs write transfers by pulling SDA low, and presents each
// received data byte with a one-cycle strobe.
//
// Ports:
//   clk        sampling clock (divided I2C clock)
//   reset      asynchronous, active-high
//   i2c_scl    bus clock from the master (input only)
//   i2c_sda    open-drain data; driven only to 1'b0 or released (z)
//   rx_data    last completed data byte, MSB received first
//   rx_valid   one-cycle pulse when rx_data updates
//   rx_rw      R/W bit of the last address byte
//   addr_match high from an accepted write address until STOP / repeated START
//   busy       high from START detection until STOP detection
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free or transaction abandoned, SDA released
// ADDR      | shifting 7 address bits + R/W
// ADDR_ACK  | address matched: drive ACK across the 9th clock
// DATA      | shifting 8 data bits
// DATA_ACK  | byte delivered: drive ACK across the 9th clock
// WAIT_STOP | not addressed (or read): ignore bus until STOP/START

module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h27,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_rw,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic [SYNC_STAGES:0]   warm;
    logic                   scl_s;
    logic                   sda_s;

    logic ev_start;
    logic ev_stop;
    logic ev_rise;
    logic ev_fall;
    logic ev_bit;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       sda_low;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

    // Synchronizers reset to the idle bus level. The warm-up shifter masks
    // edge detection until the chain and history flop hold real pin values,
    // so leaving reset mid-transfer cannot fabricate a START or an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            warm     <= '0;
            ev_start <= 1'b0;
            ev_stop  <= 1'b0;
            ev_rise  <= 1'b0;
            ev_fall  <= 1'b0;
            ev_bit   <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            warm     <= {warm[SYNC_STAGES-1:0], 1'b1};
            // SCL must be high in this and the previous cycle, which also
            // keeps an SCL rising edge from ever being seen as START/STOP.
            ev_start <= warm[SYNC_STAGES] & scl_s & scl_d & sda_d & ~sda_s;
            ev_stop  <= warm[SYNC_STAGES] & scl_s & scl_d & ~sda_d & sda_s;
            ev_rise  <= warm[SYNC_STAGES] & scl_s & ~scl_d;
            ev_fall  <= warm[SYNC_STAGES] & ~scl_s & scl_d;
            ev_bit   <= sda_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 7'd0;
            sda_low    <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_rw      <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ev_start) begin
                state      <= ADDR;
                bit_cnt    <= 3'd0;
                addr_match <= 1'b0;
                sda_low    <= 1'b0;
                busy       <= 1'b1;
            end else if (ev_stop) begin
                state      <= IDLE;
                bit_cnt    <= 3'd0;
                addr_match <= 1'b0;
                sda_low    <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE, WAIT_STOP: begin
                    end
                    ADDR: begin
                        if (ev_rise) begin
                            shift   <= {shift[5:0], ev_bit};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_rw <= ev_bit;
                                if (shift == SLAVE_ADDR && !ev_bit) begin
                                    state      <= ADDR_ACK;
                                    addr_match <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    // First falling edge ends the 8th bit: take SDA. The next
                    // one ends the ACK clock: let go and start a new byte.
                    ADDR_ACK, DATA_ACK: begin
                        if (ev_fall) begin
                            if (!sda_low) begin
                                sda_low <= 1'b1;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= DATA;
                                bit_cnt <= 3'd0;
                            end
                        end
                    end
                    DATA: begin
                        if (ev_rise) begin
                            shift   <= {shift[5:0], ev_bit};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= {shift, ev_bit};
                                rx_valid <= 1'b1;
                                state    <= DATA_ACK;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
module tb_i2c_slave_rx;

    logic       clk;
    logic       reset;
    logic       i2c_scl;
    wire        i2c_sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rw;
    logic       addr_match;
    logic       busy;

    logic m_low;
    assign i2c_sda = m_low ? 1'b0 : 1'bz;
    pullup (i2c_sda);

    i2c_slave_rx #(.SLAVE_ADDR(7'h27), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_scl    (i2c_scl),
        .i2c_sda    (i2c_sda),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_rw      (rx_rw),
        .addr_match (addr_match),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Receive monitor: records every strobe, its cycle, and flags strobes
    // longer than one cycle or rx_data moving between strobes.
    logic [7:0] rx_q[$];
    int         vcyc_q[$];
    int         width_err = 0;
    int         stab_err  = 0;
    logic       prev_v    = 1'b0;
    logic [7:0] last_d    = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            last_d = 8'h00;
            prev_v = 1'b0;
        end else begin
            if (rx_valid) begin
                rx_q.push_back(rx_data);
                vcyc_q.push_back(cyc);
                if (prev_v) width_err++;
                last_d = rx_data;
            end else if (rx_data !== last_d) begin
                stab_err++;
            end
            prev_v = rx_valid;
        end
    end

    // Per-transfer capture: index 0 is the address byte, 1.. are data bytes.
    logic [7:0] tx_b[0:8];
    logic       ack_r[0:8];
    logic       pre_r[0:8];
    logic       post_r[0:8];
    int         rise8_r[0:8];
    logic       busy_mid;
    logic       match_mid;
    int         corrupt;

    function automatic logic line_lvl();
        return (i2c_sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period starting and ending with SCL just driven low.
    task automatic send_bit(input logic b, output logic s, output int rc);
        tick(5); m_low = ~b;
        tick(3); i2c_scl = 1'b1; rc = cyc;
        tick(4); s = line_lvl();
        if (b && !s) corrupt++;
        tick(4); i2c_scl = 1'b0;
    endtask

    task automatic send_byte(input int k);
        logic s;
        int   rc;
        logic [7:0] v;
        v = tx_b[k];
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], s, rc);
            if (i == 0) rise8_r[k] = rc;
        end
        tick(5); m_low = 1'b0;
        tick(3); i2c_scl = 1'b1;
        tick(4); ack_r[k] = ~line_lvl();
        tick(4); i2c_scl = 1'b0;
        tick(3); pre_r[k]  = line_lvl();
        tick(1); post_r[k] = line_lvl();
    endtask

    task automatic do_start();
        tick(5); m_low = 1'b0;
        tick(3); i2c_scl = 1'b1;
        tick(8); m_low = 1'b1;
        tick(8); i2c_scl = 1'b0;
    endtask

    task automatic do_stop();
        tick(5); m_low = 1'b1;
        tick(3); i2c_scl = 1'b1;
        tick(8); m_low = 1'b0;
        tick(8);
    endtask

    task automatic xfer(input int nb);
        do_start();
        send_byte(0);
        busy_mid  = busy;
        match_mid = addr_match;
        for (int k = 1; k <= nb; k++) send_byte(k);
        do_stop();
    endtask

    task automatic clear_rx();
        rx_q.delete();
        vcyc_q.delete();
        corrupt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; i2c_scl = 1'b1; m_low = 1'b0;
        tick(4);
        n_tests++;
        if ({rx_data, rx_valid, rx_rw, addr_match, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000", {rx_data, rx_valid, rx_rw, addr_match, busy});
        end
        n_tests++;
        if (line_lvl() !== 1'b1) begin
            n_fail++; $display("FAIL reset_sda: got %b expected 1 (released)", line_lvl());
        end
        reset = 1'b0;
        tick(8);
        n_tests++;
        if ({rx_valid, addr_match, busy} !== 3'b000) begin
            n_fail++; $display("FAIL post_reset_idle: got %b expected 000", {rx_valid, addr_match, busy});
        end
    endtask

    task automatic test_write_single();
        clear_rx();
        tx_b[0] = 8'h4E; tx_b[1] = 8'hA5;
        xfer(1);
        n_tests++;
        if ({ack_r[0], ack_r[1]} !== 2'b11) begin
            n_fail++; $display("FAIL ws_acks: got %b expected 11", {ack_r[0], ack_r[1]});
        end
        n_tests++;
        if ({pre_r[1], post_r[1]} !== 2'b01) begin
            n_fail++; $display("FAIL ws_release_timing: got %b expected 01", {pre_r[1], post_r[1]});
        end
        n_tests++;
        if ({busy_mid, match_mid} !== 2'b11) begin
            n_fail++; $display("FAIL ws_busy_match_mid: got %b expected 11", {busy_mid, match_mid});
        end
        n_tests++;
        if (rx_q.size() !== 1) begin
            n_fail++; $display("FAIL ws_rx_count: got %0d expected 1", rx_q.size());
        end else begin
            n_tests++;
            if (rx_q[0] !== 8'hA5) begin
                n_fail++; $display("FAIL ws_rx_data: got %h expected a5", rx_q[0]);
            end
            n_tests++;
            if (vcyc_q[0] - rise8_r[1] !== 4) begin
                n_fail++; $display("FAIL ws_valid_latency: got %0d expected 4", vcyc_q[0] - rise8_r[1]);
            end
        end
        n_tests++;
        if ({busy, addr_match, rx_rw} !== 3'b000) begin
            n_fail++; $display("FAIL ws_after_stop: got %b expected 000", {busy, addr_match, rx_rw});
        end
    endtask

    task automatic test_addr_mismatch();
        clear_rx();
        tx_b[0] = 8'h50; tx_b[1] = 8'h11;
        xfer(1);
        n_tests++;
        if ({ack_r[0], ack_r[1], pre_r[0], pre_r[1]} !== 4'b0011) begin
            n_fail++; $display("FAIL mm_no_drive: got %b expected 0011", {ack_r[0], ack_r[1], pre_r[0], pre_r[1]});
        end
        n_tests++;
        if ({rx_q.size() == 0, match_mid, busy_mid, busy} !== 4'b1010) begin
            n_fail++; $display("FAIL mm_flags: got %b expected 1010", {rx_q.size() == 0, match_mid, busy_mid, busy});
        end
    endtask

    task automatic test_read_nack();
        clear_rx();
        tx_b[0] = 8'h4F;
        xfer(0);
        n_tests++;
        if ({rx_rw, ack_r[0], match_mid, addr_match} !== 4'b1000) begin
            n_fail++; $display("FAIL rd_nack: got %b expected 1000", {rx_rw, ack_r[0], match_mid, addr_match});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        clear_rx();
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
        tx_b[0] = 8'h4E;
        for (int k = 0; k < 3; k++) tx_b[k+1] = exp_b[k];
        xfer(3);
        n_tests++;
        if ({ack_r[0], ack_r[1], ack_r[2], ack_r[3]} !== 4'hF) begin
            n_fail++; $display("FAIL b2b_acks: got %b expected 1111", {ack_r[0], ack_r[1], ack_r[2], ack_r[3]});
        end
        n_tests++;
        if (rx_q.size() !== 3) begin
            n_fail++; $display("FAIL b2b_rx_count: got %0d expected 3", rx_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (rx_q[k] !== exp_b[k] || vcyc_q[k] - rise8_r[k+1] !== 4) begin
                    n_fail++;
                    $display("FAIL b2b_byte%0d: got %h lat %0d expected %h lat 4", k, rx_q[k], vcyc_q[k] - rise8_r[k+1], exp_b[k]);
                end
            end
        end
    endtask

    task automatic test_repeated_start();
        logic [7:0] p;
        logic       s;
        int         rc;
        clear_rx();
        p = 8'hF0;
        tx_b[0] = 8'h4E;
        do_start();
        send_byte(0);
        for (int i = 7; i >= 4; i--) send_bit(p[i], s, rc);
        do_start();
        n_tests++;
        if ({addr_match, busy} !== 2'b01) begin
            n_fail++; $display("FAIL rs_flags: got %b expected 01", {addr_match, busy});
        end
        tx_b[1] = 8'h3C;
        send_byte(0);
        send_byte(1);
        do_stop();
        n_tests++;
        if (rx_q.size() !== 1) begin
            n_fail++; $display("FAIL rs_rx_count: got %0d expected 1", rx_q.size());
        end else begin
            n_tests++;
            if (rx_q[0] !== 8'h3C) begin
                n_fail++; $display("FAIL rs_rx_data: got %h expected 3c", rx_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] b;
        logic       s;
        int         rc;
        clear_rx();
        tx_b[0] = 8'h4E;
        b = 8'($urandom);
        do_start();
        send_byte(0);
        for (int i = 7; i >= 0; i--) send_bit(b[i], s, rc);
        tick(5); m_low = 1'b0;
        n_tests++;
        if (line_lvl() !== 1'b0) begin
            n_fail++; $display("FAIL rm_ack_driven: got %b expected 0", line_lvl());
        end
        n_tests++;
        if (rx_q.size() !== 1 || (rx_q.size() == 1 && rx_q[0] !== b)) begin
            n_fail++; $display("FAIL rm_first_byte: got count %0d expected 1 byte %h", rx_q.size(), b);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (line_lvl() !== 1'b1) begin
            n_fail++; $display("FAIL rm_sda_async_release: got %b expected 1", line_lvl());
        end
        n_tests++;
        if ({rx_data, rx_valid, rx_rw, addr_match, busy} !== 12'h000) begin
            n_fail++; $display("FAIL rm_outputs: got %h expected 000", {rx_data, rx_valid, rx_rw, addr_match, busy});
        end
        tick(2); i2c_scl = 1'b1;
        tick(8); i2c_scl = 1'b0;
        clear_rx();
        b = 8'($urandom);
        for (int i = 7; i >= 6; i--) send_bit(b[i], s, rc);
        reset = 1'b0;
        for (int i = 5; i >= 0; i--) send_bit(b[i], s, rc);
        send_bit(1'b1, s, rc);
        tx_b[1] = 8'($urandom);
        send_byte(1);
        n_tests++;
        if ({s, ack_r[1], busy, addr_match} !== 4'b1000) begin
            n_fail++; $display("FAIL rm_ignored_after_reset: got %b expected 1000", {s, ack_r[1], busy, addr_match});
        end
        do_stop();
        n_tests++;
        if (rx_q.size() !== 0) begin
            n_fail++; $display("FAIL rm_no_valid: got %0d strobes expected 0", rx_q.size());
        end
        tx_b[0] = 8'h4E; tx_b[1] = 8'($urandom);
        xfer(1);
        n_tests++;
        if (rx_q.size() !== 1 || (rx_q.size() == 1 && rx_q[0] !== tx_b[1])) begin
            n_fail++; $display("FAIL rm_recover: got count %0d expected 1 byte %h", rx_q.size(), tx_b[1]);
        end
    endtask

    // Reference: a write to 0x27 ACKs every byte and delivers them in order;
    // anything else is never ACKed and delivers nothing.
    task automatic test_random();
        logic       exp_match;
        logic [7:0] exp_q[$];
        int         nb;
        int         sel;
        for (int it = 0; it < 10; it++) begin
            clear_rx();
            sel = int'($urandom_range(0, 3));
            tx_b[0] = (sel < 2) ? 8'h4E : (sel == 2) ? 8'h4F : 8'($urandom);
            nb = int'($urandom_range(0, 3));
            for (int k = 1; k <= nb; k++) tx_b[k] = 8'($urandom);
            exp_match = (tx_b[0][7:1] == 7'h27) && (tx_b[0][0] == 1'b0);
            exp_q.delete();
            if (exp_match) for (int k = 1; k <= nb; k++) exp_q.push_back(tx_b[k]);
            xfer(nb);
            for (int k = 0; k <= nb; k++) begin
                n_tests++;
                if ({ack_r[k], pre_r[k], post_r[k]} !== {exp_match, ~exp_match, 1'b1}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_ack_byte%0d: got %b expected %b", it, k, {ack_r[k], pre_r[k], post_r[k]}, {exp_match, ~exp_match, 1'b1});
                end
            end
            n_tests++;
            if ({busy_mid, match_mid, busy, addr_match, rx_rw, corrupt == 0} !== {1'b1, exp_match, 2'b00, tx_b[0][0], 1'b1}) begin
                n_fail++;
                $display("FAIL rnd%0d_flags: got %b expected %b", it, {busy_mid, match_mid, busy, addr_match, rx_rw, corrupt == 0}, {1'b1, exp_match, 2'b00, tx_b[0][0], 1'b1});
            end
            n_tests++;
            if (rx_q.size() !== exp_q.size()) begin
                n_fail++; $display("FAIL rnd%0d_rx_count: got %0d expected %0d", it, rx_q.size(), exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    n_tests++;
                    if (rx_q[j] !== exp_q[j] || vcyc_q[j] - rise8_r[j+1] !== 4) begin
                        n_fail++;
                        $display("FAIL rnd%0d_rx%0d: got %h lat %0d expected %h lat 4", it, j, rx_q[j], vcyc_q[j] - rise8_r[j+1], exp_q[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_strobe_integrity();
        n_tests++;
        if (width_err !== 0 || stab_err !== 0) begin
            n_fail++; $display("FAIL strobe_integrity: got width_err %0d stab_err %0d expected 0 0", width_err, stab_err);
        end
    endtask

    initial begin
        m_low = 1'b0; i2c_scl = 1'b1; reset = 1'b1; corrupt = 0;
        test_reset();
        test_write_single();
        test_addr_mismatch();
        test_read_nack();
        test_back_to_back();
        test_repeated_start();
        test_reset_mid_transfer();
        test_random();
        test_strobe_integrity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
